// File: rtl/pixel_batch_buffer.sv
// Batch capture FIFO between the pixel processor and VGA scan-out; paces the processor and serialises pixels lane 0 first.
// Optional PIXEL_BUFFER_UNDERFLOW_COUNT_EN adds a saturating 16-bit underflow_count output.
module pixel_batch_buffer #(
   parameter int NUM_PIXELS  = 8,
   parameter int PIXEL_WIDTH = 12,
   parameter int FIFO_DEPTH  = 32,
   parameter int H_PIXELS    = 640,
   parameter int V_LINES     = 480
)(
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic [NUM_PIXELS*PIXEL_WIDTH-1:0] result,
   input  logic                              result_ready,
   output logic                              start_next_batch,
   output logic                              new_frame,
   input  logic                              frame_start,
   input  logic                              pixel_read,
   output logic [PIXEL_WIDTH-1:0]            pixel_out,
   output logic                              pixel_valid,
   output logic                              underflow
`ifdef PIXEL_BUFFER_UNDERFLOW_COUNT_EN
   ,
   output logic [15:0]                       underflow_count
`endif
);

   localparam int TOTAL_BATCHES = H_PIXELS * V_LINES / NUM_PIXELS;
   localparam int BCW = $clog2(TOTAL_BATCHES + 1);
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int CW  = PW + 1;
   localparam logic [BCW-1:0] LAST_BATCH = BCW'(TOTAL_BATCHES - 1);
   localparam logic [CW-1:0]  DEPTH_C    = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0]  BATCH_C    = CW'(NUM_PIXELS);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                 r_state;
   state_t                 w_next_state;
   logic [PIXEL_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0]          r_wr_ptr;
   logic [PW-1:0]          r_rd_ptr;
   logic [CW-1:0]          r_count;
   logic [BCW-1:0]         r_batch_count;
   logic                   r_new_frame;
   logic                   r_pixel_valid;
   logic [PIXEL_WIDTH-1:0] r_pixel_out;
   logic                   r_underflow;
   logic                   w_space_ok;
   logic                   w_capture;
   logic                   w_last;
   logic                   w_pop;
   logic                   w_empty_pop;
   logic                   w_start_next;

   // frame_start wins over capture and pop in the same cycle
   assign w_space_ok  = (DEPTH_C - r_count) >= BATCH_C;
   assign w_capture   = (r_state == RUN) && !frame_start && result_ready && w_space_ok;
   assign w_last      = (r_batch_count == LAST_BATCH);
   assign w_pop       = pixel_read && !frame_start && (r_count != '0);
   assign w_empty_pop = pixel_read && !frame_start && (r_count == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      if (frame_start)
         w_next_state = RUN;
      else if (w_capture && w_last)
         w_next_state = IDLE;
   end

   always_comb begin
      w_start_next = 1'b0;
      if (w_capture && !w_last)
         w_start_next = 1'b1;
   end

   // Whole batch lands in one cycle; alignment to NUM_PIXELS keeps it clear of the wrap
   always_ff @(posedge clk) begin
      if (w_capture) begin
         for (int i = 0; i < NUM_PIXELS; i++)
            r_mem[r_wr_ptr + PW'(i)] <= result[i*PIXEL_WIDTH +: PIXEL_WIDTH];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_batch_count <= '0;
         r_new_frame   <= 1'b0;
         r_pixel_valid <= 1'b0;
         r_pixel_out   <= '0;
         r_underflow   <= 1'b0;
      end else begin
         r_new_frame   <= frame_start;
         r_pixel_valid <= w_pop;
         if (frame_start) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_batch_count <= '0;
            r_pixel_out   <= '0;
            r_underflow   <= 1'b0;
         end else begin
            if (w_capture) begin
               r_wr_ptr      <= r_wr_ptr + PW'(NUM_PIXELS);
               r_batch_count <= r_batch_count + BCW'(1);
            end
            if (w_pop) begin
               r_rd_ptr    <= r_rd_ptr + PW'(1);
               r_pixel_out <= r_mem[r_rd_ptr];
            end else if (w_empty_pop) begin
               r_pixel_out <= '0;
               r_underflow <= 1'b1;
            end
            case ({w_capture, w_pop})
               2'b10:   r_count <= r_count + BATCH_C;
               2'b01:   r_count <= r_count - CW'(1);
               2'b11:   r_count <= r_count + BATCH_C - CW'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

`ifdef PIXEL_BUFFER_UNDERFLOW_COUNT_EN
   logic [15:0] r_underflow_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_underflow_count <= '0;
      else if (frame_start)
         r_underflow_count <= '0;
      else if (w_empty_pop && (r_underflow_count != 16'hFFFF))
         r_underflow_count <= r_underflow_count + 16'd1;
   end

   assign underflow_count = r_underflow_count;
`endif

   assign start_next_batch = w_start_next;
   assign new_frame        = r_new_frame;
   assign pixel_valid      = r_pixel_valid;
   assign pixel_out        = r_pixel_out;
   assign underflow        = r_underflow;

endmodule

// File: tb/tb_pixel_batch_buffer.sv
// Directed bench for pixel_batch_buffer: vector table for basic capture/pop plus hand sequences for
// back-pressure, wrap, full-frame pacing, frame_start priority and asynchronous reset.
module tb_pixel_batch_buffer;

   localparam int NP      = 8;
   localparam int PXW     = 12;
   localparam int FD      = 32;
   localparam int HP      = 32;
   localparam int VL      = 4;
   localparam int BATCHES = HP * VL / NP;
   localparam int RW      = NP * PXW;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic [RW-1:0]  result = '0;
   logic           result_ready = 1'b0;
   logic           frame_start = 1'b0;
   logic           pixel_read = 1'b0;
   logic           start_next_batch;
   logic           new_frame;
   logic [PXW-1:0] pixel_out;
   logic           pixel_valid;
   logic           underflow;

   pixel_batch_buffer #(
      .NUM_PIXELS (NP),
      .PIXEL_WIDTH(PXW),
      .FIFO_DEPTH (FD),
      .H_PIXELS   (HP),
      .V_LINES    (VL)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .result          (result),
      .result_ready    (result_ready),
      .start_next_batch(start_next_batch),
      .new_frame       (new_frame),
      .frame_start     (frame_start),
      .pixel_read      (pixel_read),
      .pixel_out       (pixel_out),
      .pixel_valid     (pixel_valid),
      .underflow       (underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic           fs;
      logic           rr;
      logic           rd;
      logic [RW-1:0]  res;
      logic           snb;
      logic           nf;
      logic           pv;
      logic [PXW-1:0] po;
      logic           uf;
   } vec_t;

   vec_t           vecs [14];
   int             errors = 0;
   int             checks = 0;
   int             snbPulses = 0;
   logic [PXW-1:0] expQ [$];
   logic [PXW-1:0] expPo = '0;
   logic           expUf = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [RW-1:0] mkBatch(input int b);
      logic [RW-1:0] r;
      r = '0;
      for (int i = 0; i < NP; i++) r[i*PXW +: PXW] = PXW'(b * 16 + i);
      return r;
   endfunction

   function automatic vec_t mkVec(input logic fs, rr, rd, input logic [RW-1:0] res,
                                  input logic snb, nf, pv, input logic [PXW-1:0] po, input logic uf);
      vec_t v;
      v.fs = fs; v.rr = rr; v.rd = rd; v.res = res;
      v.snb = snb; v.nf = nf; v.pv = pv; v.po = po; v.uf = uf;
      return v;
   endfunction

   // Called at posedge+1: drive, sample the combinational pulse mid-cycle, then step past the edge
   task automatic applyStimulus(input vec_t v, input string tag);
      frame_start  = v.fs;
      result_ready = v.rr;
      pixel_read   = v.rd;
      result       = v.res;
      #3;
      check({tag, " start_next_batch"}, 32'(start_next_batch), 32'(v.snb));
      if (start_next_batch) snbPulses++;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input vec_t v, input string tag);
      check({tag, " new_frame"},   32'(new_frame),   32'(v.nf));
      check({tag, " pixel_valid"}, 32'(pixel_valid), 32'(v.pv));
      check({tag, " pixel_out"},   32'(pixel_out),   32'(v.po));
      check({tag, " underflow"},   32'(underflow),   32'(v.uf));
   endtask

   // Expected registered outputs come from a pixel queue the bench keeps itself
   task automatic seqCycle(input logic fs, rr, rd, input logic [RW-1:0] res,
                           input logic cap, snb, input string tag);
      vec_t v;
      v = mkVec(fs, rr, rd, res, snb, 1'b0, 1'b0, '0, 1'b0);
      if (fs) begin
         expQ.delete();
         v.nf  = 1'b1;
         expPo = '0;
         expUf = 1'b0;
      end else begin
         if (rd) begin
            if (expQ.size() > 0) begin
               v.pv  = 1'b1;
               expPo = expQ.pop_front();
            end else begin
               expPo = '0;
               expUf = 1'b1;
            end
         end
         if (cap)
            for (int i = 0; i < NP; i++) expQ.push_back(res[i*PXW +: PXW]);
      end
      v.po = expPo;
      v.uf = expUf;
      applyStimulus(v, tag);
      checkOutput(v, tag);
   endtask

   task automatic runFrame(input int base);
      snbPulses = 0;
      seqCycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, "frame start");
      for (int b = 0; b < BATCHES; b++) begin
         seqCycle(1'b0, 1'b1, 1'b0, mkBatch(base + b), 1'b1, (b != BATCHES - 1), "frame capture");
         for (int p = 0; p < NP; p++)
            seqCycle(1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0, "frame drain");
      end
      check("frame pulse count", 32'(snbPulses), 32'(BATCHES - 1));
      for (int k = 0; k < 2; k++)
         seqCycle(1'b0, 1'b1, 1'b1, mkBatch(99), 1'b0, 1'b0, "idle ignore");
   endtask

   initial begin
      logic [RW-1:0] lanes;
      lanes = {12'h008, 12'h007, 12'h006, 12'h005, 12'h004, 12'h003, 12'h002, 12'h001};

      vecs[0]  = mkVec(1'b0, 1'b1, 1'b0, lanes, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
      vecs[1]  = mkVec(1'b1, 1'b0, 1'b0, '0,    1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
      vecs[2]  = mkVec(1'b0, 1'b0, 1'b0, '0,    1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
      vecs[3]  = mkVec(1'b0, 1'b1, 1'b0, lanes, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
      for (int p = 0; p < NP; p++)
         vecs[4+p] = mkVec(1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b1, PXW'(p + 1), 1'b0);
      vecs[12] = mkVec(1'b0, 1'b0, 1'b1, '0,    1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
      vecs[13] = mkVec(1'b0, 1'b0, 1'b0, '0,    1'b0, 1'b0, 1'b0, 12'h000, 1'b1);

      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset start_next_batch", 32'(start_next_batch), 32'd0);
      check("reset new_frame",        32'(new_frame),        32'd0);
      check("reset pixel_valid",      32'(pixel_valid),      32'd0);
      check("reset pixel_out",        32'(pixel_out),        32'd0);
      check("reset underflow",        32'(underflow),        32'd0);
      reset_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i], $sformatf("vec%0d", i));
         checkOutput(vecs[i], $sformatf("vec%0d", i));
      end

      // Back-pressure at full FIFO, then capture+pop across the pointer wrap
      seqCycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, "bp frame");
      for (int b = 1; b <= 4; b++)
         seqCycle(1'b0, 1'b1, 1'b0, mkBatch(b), 1'b1, 1'b1, "bp fill");
      seqCycle(1'b0, 1'b1, 1'b0, mkBatch(5), 1'b0, 1'b0, "bp full hold");
      for (int p = 0; p < NP; p++)
         seqCycle(1'b0, 1'b1, 1'b1, mkBatch(5), 1'b0, 1'b0, "bp pop no space");
      seqCycle(1'b0, 1'b1, 1'b1, mkBatch(5), 1'b1, 1'b1, "capture with pop");
      for (int p = 0; p < 31; p++)
         seqCycle(1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0, "wrap drain");
      seqCycle(1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0, "wrap underflow");

      runFrame(32);
      runFrame(48);

      // frame_start priority over capture and pop
      seqCycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, "prio frame");
      seqCycle(1'b0, 1'b1, 1'b0, mkBatch(60), 1'b1, 1'b1, "prio fill");
      seqCycle(1'b0, 1'b1, 1'b0, mkBatch(61), 1'b1, 1'b1, "prio fill");
      seqCycle(1'b1, 1'b1, 1'b1, mkBatch(62), 1'b0, 1'b0, "prio coincident");
      seqCycle(1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0, "prio flushed");
      seqCycle(1'b0, 1'b1, 1'b0, mkBatch(63), 1'b1, 1'b1, "prio refill");
      seqCycle(1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0, "pre reset pop");

      // Asynchronous reset mid-frame
      result_ready = 1'b1;
      result       = mkBatch(64);
      #2;
      check("pre reset start_next_batch", 32'(start_next_batch), 32'd1);
      reset_n = 1'b0;
      #1;
      check("async start_next_batch", 32'(start_next_batch), 32'd0);
      check("async new_frame",        32'(new_frame),        32'd0);
      check("async pixel_valid",      32'(pixel_valid),      32'd0);
      check("async pixel_out",        32'(pixel_out),        32'd0);
      check("async underflow",        32'(underflow),        32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("post reset start_next_batch", 32'(start_next_batch), 32'd0);
      check("post reset pixel_valid",      32'(pixel_valid),      32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
